fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues a request at pc, waits for the response with a
// bounded retry, holds the fetched word for the controller and computes the next pc.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pcsrc,
    input  logic        jump,
    input  logic [31:0] signimm,
    input  logic        advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    output logic        fetch_timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_HOLD
    } state_t;

    localparam logic [31:0] PC_INIT     = RESET_PC & ~32'h3;
    localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  cnt_inc;
    logic [31:0] pc_next;

    assign pcplus4       = pc_q + 32'd4;
    assign pc            = pc_q;
    assign imem_addr     = pc_q;
    assign instr         = instr_q;
    assign op            = instr_q[31:26];
    assign funct         = instr_q[5:0];
    assign imem_req      = (state_q == S_FETCH);
    assign instr_valid   = (state_q == S_HOLD);
    assign fetch_timeout = timeout_q;
    assign cnt_inc       = cnt_q + 8'd1;

    // Jump wins over branch; both targets keep bits [1:0] at zero.
    always_comb begin
        if (jump)
            pc_next = {pcplus4[31:28], instr_q[25:0], 2'b00};
        else if (pcsrc)
            pc_next = pcplus4 + (signimm << 2);
        else
            pc_next = pcplus4;
    end

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ready) begin
                    if (imem_rvalid) begin
                        instr_d = imem_rdata;
                        state_d = S_HOLD;
                    end else begin
                        cnt_d   = 8'd0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                // Data on the final counted cycle still wins over the timeout.
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = S_HOLD;
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    timeout_d = 1'b1;
                    cnt_d     = 8'd0;
                    state_d   = S_FETCH;
                end
            end
            S_HOLD: begin
                if (advance) begin
                    pc_d    = pc_next;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            pc_q      <= PC_INIT;
            instr_q   <= 32'd0;
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a phase-level model is compared every cycle,
// and hand-computed literals pin the key scenarios.
module tb_fetch_unit;

    localparam logic [31:0] P_RESET_PC = 32'h0000_0003;
    localparam int          P_TIMEOUT  = 4;

    localparam int PH_IDLE = 0, PH_REQ = 1, PH_WAIT = 2, PH_HOLD = 3;

    logic        clk = 1'b0;
    logic        reset_n, pcsrc, jump, advance, imem_ready, imem_rvalid;
    logic [31:0] signimm, imem_rdata;
    logic        imem_req, instr_valid, fetch_timeout;
    logic [31:0] imem_addr, instr, pc, pcplus4;
    logic [5:0]  op, funct;

    int n_vec = 0;
    int n_err = 0;

    // Model state: what the fetch unit is doing, expressed as phase plus counters.
    int          m_phase;
    int          m_waited;
    logic [31:0] m_pc, m_instr, m_p4;
    logic        m_to;

    fetch_unit #(.RESET_PC(P_RESET_PC), .TIMEOUT(P_TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .pcsrc(pcsrc), .jump(jump), .signimm(signimm),
        .advance(advance), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .op(op), .funct(funct), .pc(pc),
        .pcplus4(pcplus4), .fetch_timeout(fetch_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change only at negedge+1, so at the negedge they still hold what the
    // last rising edge sampled: step the model for that edge, then compare.
    always @(negedge clk) begin
        if (!reset_n) begin
            m_phase  = PH_IDLE;
            m_pc     = P_RESET_PC & ~32'h3;
            m_instr  = 32'd0;
            m_waited = 0;
            m_to     = 1'b0;
        end else begin
            case (m_phase)
                PH_IDLE: m_phase = PH_REQ;
                PH_REQ: if (imem_ready) begin
                    if (imem_rvalid) begin
                        m_instr = imem_rdata;
                        m_phase = PH_HOLD;
                    end else begin
                        m_waited = 0;
                        m_phase  = PH_WAIT;
                    end
                end
                PH_WAIT: begin
                    m_waited = m_waited + 1;
                    if (imem_rvalid) begin
                        m_instr = imem_rdata;
                        m_phase = PH_HOLD;
                    end else if (m_waited == P_TIMEOUT) begin
                        m_to    = 1'b1;
                        m_phase = PH_REQ;
                    end
                end
                PH_HOLD: if (advance) begin
                    m_p4 = m_pc + 32'd4;
                    if (jump)       m_pc = {m_p4[31:28], m_instr[25:0], 2'b00};
                    else if (pcsrc) m_pc = m_p4 + signimm * 32'd4;
                    else            m_pc = m_p4;
                    m_phase = PH_REQ;
                end
                default: m_phase = PH_IDLE;
            endcase
        end
        m_p4 = m_pc + 32'd4;
        check("m_imem_req", {31'd0, imem_req}, {31'd0, m_phase == PH_REQ});
        check("m_instr_valid", {31'd0, instr_valid}, {31'd0, m_phase == PH_HOLD});
        check("m_pc", pc, m_pc);
        check("m_imem_addr", imem_addr, m_pc);
        check("m_pcplus4", pcplus4, m_p4);
        check("m_instr", instr, m_instr);
        check("m_op", {26'd0, op}, {26'd0, m_instr[31:26]});
        check("m_funct", {26'd0, funct}, {26'd0, m_instr[5:0]});
        check("m_fetch_timeout", {31'd0, fetch_timeout}, {31'd0, m_to});
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_advance(input logic j, input logic p, input logic [31:0] imm);
        advance = 1'b1; jump = j; pcsrc = p; signimm = imm;
        tick();
        advance = 1'b0; jump = 1'b0; pcsrc = 1'b0; signimm = 32'd0;
    endtask

    task automatic fetch_now(input logic [31:0] data);
        imem_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = data;
        tick();
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    endtask

    initial begin
        reset_n = 1'b0; pcsrc = 1'b0; jump = 1'b0; advance = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; signimm = 32'd0; imem_rdata = 32'd0;
        tick();
        tick();
        check("rst_pc_low_bits_forced", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_timeout", {31'd0, fetch_timeout}, 32'd0);

        reset_n = 1'b1;
        tick();
        check("first_req", {31'd0, imem_req}, 32'd1);
        fetch_now(32'h2008_0005);
        check("hold_valid", {31'd0, instr_valid}, 32'd1);
        check("hold_op", {26'd0, op}, 32'h08);
        check("hold_funct", {26'd0, funct}, 32'h05);
        check("hold_pc", pc, 32'h0);

        imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        tick();
        imem_rvalid = 1'b0; imem_rdata = 32'd0;
        check("rvalid_in_hold_ignored", instr, 32'h2008_0005);

        do_advance(1'b0, 1'b1, 32'd15);
        check("branch_fwd_pc", pc, 32'h40);
        fetch_now(32'h1234_5678);
        do_advance(1'b0, 1'b1, 32'hFFFF_FFFE);
        check("branch_back_pc", pc, 32'h3C);
        check("branch_back_addr", imem_addr, 32'h3C);
        check("branch_back_req", {31'd0, imem_req}, 32'd1);

        advance = 1'b1; jump = 1'b1;
        tick();
        advance = 1'b0; jump = 1'b0;
        check("advance_in_fetch_ignored", pc, 32'h3C);

        fetch_now(32'h0000_0000);
        do_advance(1'b0, 1'b1, 32'h03FF_FFF4);
        check("far_branch_pc", pc, 32'h1000_0010);
        fetch_now(32'h0800_0100);
        do_advance(1'b1, 1'b1, 32'd5);
        check("jump_over_branch_pc", pc, 32'h1000_0400);
        fetch_now(32'h0);
        do_advance(1'b0, 1'b1, 32'h3BFF_FEFE);
        check("top_pc", pc, 32'hFFFF_FFFC);
        fetch_now(32'h0);
        check("top_pcplus4_wrap", pcplus4, 32'h0);
        do_advance(1'b0, 1'b0, 32'h0);
        check("pc_wrap", pc, 32'h0);

        // Data on the last counted WAIT cycle must be taken, not timed out.
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        repeat (P_TIMEOUT - 1) tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hABCD_0001;
        tick();
        imem_rvalid = 1'b0; imem_rdata = 32'd0;
        check("late_data_valid", {31'd0, instr_valid}, 32'd1);
        check("late_data_instr", instr, 32'hABCD_0001);
        check("late_data_no_timeout", {31'd0, fetch_timeout}, 32'd0);

        do_advance(1'b0, 1'b0, 32'h0);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        repeat (P_TIMEOUT - 1) tick();
        check("timeout_not_yet", {31'd0, fetch_timeout}, 32'd0);
        tick();
        check("timeout_flag", {31'd0, fetch_timeout}, 32'd1);
        check("timeout_reissue_req", {31'd0, imem_req}, 32'd1);
        check("timeout_reissue_pc", imem_addr, 32'h4);
        fetch_now(32'h0000_0777);
        check("timeout_sticky", {31'd0, fetch_timeout}, 32'd1);

        do_advance(1'b0, 1'b0, 32'h0);
        repeat (10) tick();
        check("stall_req", {31'd0, imem_req}, 32'd1);
        check("stall_addr", imem_addr, 32'h8);
        check("stall_valid", {31'd0, instr_valid}, 32'd0);

        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        reset_n = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        check("rst_wait_instr", instr, 32'h0);
        check("rst_wait_pc", pc, 32'h0);
        check("rst_wait_req", {31'd0, imem_req}, 32'd0);
        check("rst_wait_timeout", {31'd0, fetch_timeout}, 32'd0);
        tick();
        check("rst_wait_first_req", {31'd0, imem_req}, 32'd1);
        check("rst_wait_instr_after", instr, 32'h0);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
